// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1x4 packet demultiplexer.
package demux_pkg;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;
endpackage

// File: rtl/demux_out_slot.sv
// Single-entry output register: holds one beat (data, last, dest) and
// presents it on the valid line of its destination port until taken.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_last,
  input  logic [SEL_W-1:0]   i_dest,
  input  logic [NUM_OUT-1:0] i_out_ready,
  output logic [NUM_OUT-1:0] o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_last,
  output logic               o_space
);

  logic               r_full;
  logic [WIDTH-1:0]   r_data;
  logic               r_last;
  logic [SEL_W-1:0]   r_dest;
  logic               w_drain;

  // Only the addressed port's ready can release the slot.
  assign w_drain = r_full && i_out_ready[r_dest];
  assign o_space = !r_full || i_out_ready[r_dest];
  assign o_data  = r_data;
  assign o_last  = r_last;

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_valid
      assign o_valid[gi] = r_full && (r_dest == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
      r_dest <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_last <= i_last;
      r_dest <= i_dest;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x4_stream.sv
// Packet-level 1-to-4 stream demultiplexer: the first beat's in_sel picks
// the port, later beats of the same packet follow it until in_last.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_route;
  logic [SEL_W-1:0] w_route_next;
  logic [SEL_W-1:0] w_dest;
  logic             r_en;
  logic             w_space;
  logic             w_accept;

  // r_en keeps in_ready low until the first clock edge after reset release.
  assign in_ready = r_en && w_space;
  assign w_accept = in_valid && in_ready;
  assign w_dest   = (r_state == PKT) ? r_route : in_sel;
  assign busy     = (r_state == PKT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_route <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_route <= w_route_next;
      r_en    <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_route_next = r_route;
    case (r_state)
      IDLE: begin
        if (w_accept && !in_last) begin
          w_state_next = PKT;
          w_route_next = in_sel;
        end
      end
      PKT: begin
        if (w_accept && in_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  demux_out_slot #(
    .WIDTH(WIDTH)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_data     (in_data),
    .i_last     (in_last),
    .i_dest     (w_dest),
    .i_out_ready(out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_last     (out_last),
    .o_space    (w_space)
  );

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed bench for demux_1x4_stream with a packet-level reference model.
module tb_demux_1x4_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         p;
    int         cyc;
  } beat_t;

  beat_t mq[$];    // beats accepted but not yet delivered (model)
  beat_t olog[$];  // transfers actually observed on the outputs

  demux_1x4_stream #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state: packet context and output-enable after reset.
  logic       m_in_pkt = 1'b0;
  int         m_route  = 0;
  logic       m_en     = 1'b0;

  initial begin : monitor
    logic [3:0] exp_valid;
    logic       exp_rdy;
    logic       take_in;
    logic       drain;
    logic [3:0] obs;
    beat_t      nb;
    beat_t      ob;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_in_pkt = 1'b0;
        m_en     = 1'b0;
        continue;
      end
      exp_valid = (mq.size() != 0) ? (4'b0001 << mq[0].p) : 4'b0000;
      chk("out_valid", out_valid, exp_valid);
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0].d);
        chk("out_last", out_last, mq[0].l);
      end
      exp_rdy = m_en && ((mq.size() == 0) || out_ready[mq[0].p]);
      chk("in_ready", in_ready, exp_rdy);
      chk("busy", busy, m_in_pkt);
      take_in = in_valid && exp_rdy;
      drain   = (mq.size() != 0) && out_ready[mq[0].p];
      nb.d    = in_data;
      nb.l    = in_last;
      nb.p    = m_in_pkt ? m_route : int'(in_sel);
      nb.cyc  = 0;
      obs     = out_valid & out_ready;
      ob.d    = out_data;
      ob.l    = out_last;
      ob.p    = -1;
      for (int i = 0; i < 4; i++) if (obs[i]) ob.p = i;
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_in_pkt = 1'b0;
        m_en     = 1'b0;
      end else begin
        cyc++;
        ob.cyc = cyc;
        if (obs != 4'b0000) olog.push_back(ob);
        if (drain) void'(mq.pop_front());
        if (take_in) begin
          mq.push_back(nb);
          if (!m_in_pkt && !nb.l) begin
            m_in_pkt = 1'b1;
            m_route  = nb.p;
          end else if (m_in_pkt && nb.l) begin
            m_in_pkt = 1'b0;
          end
        end
        m_en = 1'b1;
      end
    end
  end

  // Offer one beat and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] s);
    int   n;
    logic acc;
    n        = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: beat %0h never accepted within %0d cycles", d, n);
    end
  endtask

  task automatic expect_out(input logic [7:0] d, input logic l, input int p, output int c);
    beat_t e;
    c = -1;
    chk("log_nonempty", olog.size() != 0, 1);
    if (olog.size() != 0) begin
      e = olog.pop_front();
      c = e.cyc;
      chk("log_data", e.d, d);
      chk("log_port", e.p, p);
      chk("log_last", e.l, l);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : driver
    int c0, c1, c2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_sel    = 2'd0;
    out_ready = 4'hF;
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_before_edge", in_ready, 0);
    idle(1);
    chk("in_ready_after_edge", in_ready, 1);

    // Single-beat packet to port 2
    send(8'hA5, 1'b1, 2'd2);
    chk("t1_out_valid", out_valid, 4'b0100);
    chk("t1_out_data", out_data, 8'hA5);
    chk("t1_out_last", out_last, 1);
    chk("t1_busy", busy, 0);
    idle(2);
    expect_out(8'hA5, 1'b1, 2, c0);

    // Three beats to port 1, in_sel changes mid-packet
    send(8'h11, 1'b0, 2'd1);
    chk("t2_busy_after_b1", busy, 1);
    send(8'h22, 1'b0, 2'd3);
    send(8'h33, 1'b1, 2'd3);
    chk("t2_busy_after_b3", busy, 0);
    idle(2);
    expect_out(8'h11, 1'b0, 1, c0);
    expect_out(8'h22, 1'b0, 1, c0);
    expect_out(8'h33, 1'b1, 1, c0);

    // Backpressure on port 0 for 4 cycles
    out_ready = 4'b1110;
    send(8'h50, 1'b0, 2'd0);
    chk("t3_in_ready_stalled", in_ready, 0);
    chk("t3_out_data_held", out_data, 8'h50);
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 4'hF;
      end
    join_none
    send(8'h51, 1'b0, 2'd2);
    send(8'h52, 1'b1, 2'd2);
    idle(2);
    expect_out(8'h50, 1'b0, 0, c0);
    expect_out(8'h51, 1'b0, 0, c0);
    expect_out(8'h52, 1'b1, 0, c0);

    // Back-to-back packets, ports 1 and 2 not ready
    out_ready = 4'b1001;
    send(8'h31, 1'b0, 2'd3);
    send(8'h32, 1'b1, 2'd1);
    send(8'h40, 1'b1, 2'd0);
    idle(2);
    expect_out(8'h31, 1'b0, 3, c0);
    expect_out(8'h32, 1'b1, 3, c1);
    expect_out(8'h40, 1'b1, 0, c2);
    chk("t4_no_bubble_a", c1, c0 + 1);
    chk("t4_no_bubble_b", c2, c1 + 1);

    // Reset after beat 2 of a 4-beat packet
    out_ready = 4'hF;
    send(8'h61, 1'b0, 2'd2);
    send(8'h62, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 4'b0000);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_out_data", out_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_out(8'h61, 1'b0, 2, c0);
    send(8'h70, 1'b0, 2'd1);
    send(8'h71, 1'b1, 2'd3);
    idle(2);
    expect_out(8'h70, 1'b0, 1, c0);
    expect_out(8'h71, 1'b1, 1, c0);
    chk("end_log_empty", olog.size(), 0);
    chk("end_model_empty", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
